// File: rtl/pipe_ctrl_unit.sv
// Control path for the 5-stage RV32I core: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, stall/flush handling and the ECALL/illegal halt sequencer.
module pipe_ctrl_unit #(
  parameter int DRAIN_CYCLES      = 3,
  parameter int HALT_ON_ILLEGAL   = 0,
  parameter int ECALL_ALWAYS_HALT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       id_valid,
  input  logic       ecall_halt_cond,
  input  logic       stall,
  input  logic       flush,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       if_flush,
  output logic       ex_valid,
  output logic       ex_alu_src,
  output logic       ex_is_jal,
  output logic       ex_is_jalr,
  output logic       ex_branch,
  output logic [6:0] ex_alu_op,
  output logic       mem_valid,
  output logic       mem_read,
  output logic       mem_write,
  output logic       wb_valid,
  output logic       wb_mem_to_reg,
  output logic       wb_reg_write,
  output logic       wb_pc_to_reg,
  output logic       halted,
  output logic       illegal_inst
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef struct packed {
    logic       valid;
    logic       alu_src;
    logic       is_jal;
    logic       is_jalr;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       pc_to_reg;
    logic [6:0] alu_op;
  } ex_ctl_t;

  typedef struct packed {
    logic valid;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
    logic pc_to_reg;
  } mem_ctl_t;

  typedef struct packed {
    logic valid;
    logic mem_to_reg;
    logic reg_write;
    logic pc_to_reg;
  } wb_ctl_t;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t   state_reg;
  logic [3:0] drain_cnt_reg;
  logic     illegal_reg;
  ex_ctl_t  idex_reg;
  mem_ctl_t exmem_reg;
  wb_ctl_t  memwb_reg;

  ex_ctl_t  dec;
  logic     is_ecall;
  logic     is_illegal;
  logic     accept;
  logic     halt_cause;

  always_comb begin
    dec        = '0;
    is_ecall   = 1'b0;
    is_illegal = 1'b0;
    if (id_valid) begin
      dec.valid  = 1'b1;
      dec.alu_op = opcode;
      case (opcode)
        OP_R:      dec.reg_write = 1'b1;
        OP_I:      begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
        OP_LOAD:   begin
                     dec.alu_src    = 1'b1;
                     dec.mem_read   = 1'b1;
                     dec.mem_to_reg = 1'b1;
                     dec.reg_write  = 1'b1;
                   end
        OP_STORE:  begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
        OP_BRANCH: dec.branch = 1'b1;
        OP_JAL:    begin
                     dec.is_jal    = 1'b1;
                     dec.alu_src   = 1'b1;
                     dec.reg_write = 1'b1;
                     dec.pc_to_reg = 1'b1;
                   end
        OP_JALR:   begin
                     dec.is_jalr   = 1'b1;
                     dec.alu_src   = 1'b1;
                     dec.reg_write = 1'b1;
                     dec.pc_to_reg = 1'b1;
                   end
        OP_ECALL:  is_ecall = 1'b1;
        default:   begin
                     // Illegal opcodes travel as an all-zero bubble.
                     dec        = '0;
                     is_illegal = 1'b1;
                   end
      endcase
    end
  end

  assign accept     = (state_reg == RUN) && !flush && !stall && id_valid;
  assign halt_cause = (is_ecall && (ecall_halt_cond || (ECALL_ALWAYS_HALT != 0))) ||
                      (is_illegal && (HALT_ON_ILLEGAL != 0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      drain_cnt_reg <= '0;
      illegal_reg   <= 1'b0;
      idex_reg      <= '0;
      exmem_reg     <= '0;
      memwb_reg     <= '0;
    end else begin
      // Later stages always advance; only ID/EX sees stall/flush/halt.
      exmem_reg <= '{valid: idex_reg.valid, mem_read: idex_reg.mem_read,
                     mem_write: idex_reg.mem_write, mem_to_reg: idex_reg.mem_to_reg,
                     reg_write: idex_reg.reg_write, pc_to_reg: idex_reg.pc_to_reg};
      memwb_reg <= '{valid: exmem_reg.valid, mem_to_reg: exmem_reg.mem_to_reg,
                     reg_write: exmem_reg.reg_write, pc_to_reg: exmem_reg.pc_to_reg};
      case (state_reg)
        RUN: begin
          idex_reg <= accept ? dec : '0;
          if (accept && is_illegal) illegal_reg <= 1'b1;
          if (accept && halt_cause) begin
            state_reg     <= DRAIN;
            drain_cnt_reg <= 4'(DRAIN_CYCLES);
          end
        end
        DRAIN: begin
          idex_reg      <= '0;
          drain_cnt_reg <= drain_cnt_reg - 4'd1;
          if (drain_cnt_reg == 4'd1) state_reg <= HALTED;
        end
        default: idex_reg <= '0;
      endcase
    end
  end

  // Front-end enables respond in the same cycle as the hazard inputs.
  assign pc_write     = (state_reg == RUN) && (flush || !stall);
  assign ifid_write   = (state_reg == RUN) && (flush || !stall);
  assign if_flush     = (state_reg == RUN) && flush;
  assign halted       = (state_reg == HALTED);
  assign illegal_inst = illegal_reg;

  assign ex_valid      = idex_reg.valid;
  assign ex_alu_src    = idex_reg.alu_src;
  assign ex_is_jal     = idex_reg.is_jal;
  assign ex_is_jalr    = idex_reg.is_jalr;
  assign ex_branch     = idex_reg.branch;
  assign ex_alu_op     = idex_reg.alu_op;
  assign mem_valid     = exmem_reg.valid;
  assign mem_read      = exmem_reg.mem_read;
  assign mem_write     = exmem_reg.mem_write;
  assign wb_valid      = memwb_reg.valid;
  assign wb_mem_to_reg = memwb_reg.mem_to_reg;
  assign wb_reg_write  = memwb_reg.reg_write;
  assign wb_pc_to_reg  = memwb_reg.pc_to_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: expectations are queued with their due cycle
// when an instruction is driven and compared when that cycle is reached.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_EC = 7'b1110011, OP_BAD = 7'b1111111;

  localparam int S_PCW = 0, S_IFIDW = 1, S_IFFL = 2, S_EXV = 3, S_EXSRC = 4, S_EXJAL = 5;
  localparam int S_EXJALR = 6, S_EXBR = 7, S_EXOP = 8, S_MEMV = 9, S_MEMRD = 10, S_MEMWR = 11;
  localparam int S_WBV = 12, S_WBM2R = 13, S_WBRW = 14, S_WBPC = 15, S_HALT = 16, S_ILL = 17;
  localparam int S_D2HALT = 18, S_D2PCW = 19;

  logic clk = 1'b0, reset = 1'b0;
  logic [6:0] opcode = '0;
  logic id_valid = 1'b0, ecall_halt_cond = 1'b0, stall = 1'b0, flush = 1'b0;

  logic pc_write, ifid_write, if_flush, ex_valid, ex_alu_src, ex_is_jal, ex_is_jalr, ex_branch;
  logic [6:0] ex_alu_op;
  logic mem_valid, mem_read, mem_write, wb_valid, wb_mem_to_reg, wb_reg_write, wb_pc_to_reg;
  logic halted, illegal_inst;

  logic d2_pc_write, d2_ifid_write, d2_if_flush, d2_ex_valid, d2_ex_alu_src, d2_ex_is_jal;
  logic d2_ex_is_jalr, d2_ex_branch;
  logic [6:0] d2_ex_alu_op;
  logic d2_mem_valid, d2_mem_read, d2_mem_write, d2_wb_valid, d2_wb_mem_to_reg, d2_wb_reg_write;
  logic d2_wb_pc_to_reg, d2_halted, d2_illegal_inst;

  int n_vec = 0, n_miss = 0, cur = 0;

  typedef struct {
    int         cyc;
    int         sig;
    logic [6:0] val;
    string      tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cur <= cur + 1;

  pipe_ctrl_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
    .ecall_halt_cond(ecall_halt_cond), .stall(stall), .flush(flush),
    .pc_write(pc_write), .ifid_write(ifid_write), .if_flush(if_flush),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_is_jal(ex_is_jal),
    .ex_is_jalr(ex_is_jalr), .ex_branch(ex_branch), .ex_alu_op(ex_alu_op),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_pc_to_reg(wb_pc_to_reg), .halted(halted), .illegal_inst(illegal_inst)
  );

  pipe_ctrl_unit #(.DRAIN_CYCLES(2), .HALT_ON_ILLEGAL(1), .ECALL_ALWAYS_HALT(0)) dut2 (
    .clk(clk), .reset(reset), .opcode(opcode), .id_valid(id_valid),
    .ecall_halt_cond(ecall_halt_cond), .stall(stall), .flush(flush),
    .pc_write(d2_pc_write), .ifid_write(d2_ifid_write), .if_flush(d2_if_flush),
    .ex_valid(d2_ex_valid), .ex_alu_src(d2_ex_alu_src), .ex_is_jal(d2_ex_is_jal),
    .ex_is_jalr(d2_ex_is_jalr), .ex_branch(d2_ex_branch), .ex_alu_op(d2_ex_alu_op),
    .mem_valid(d2_mem_valid), .mem_read(d2_mem_read), .mem_write(d2_mem_write),
    .wb_valid(d2_wb_valid), .wb_mem_to_reg(d2_wb_mem_to_reg), .wb_reg_write(d2_wb_reg_write),
    .wb_pc_to_reg(d2_wb_pc_to_reg), .halted(d2_halted), .illegal_inst(d2_illegal_inst)
  );

  function automatic logic [6:0] get_sig(int s);
    case (s)
      S_PCW:    return {6'b0, pc_write};
      S_IFIDW:  return {6'b0, ifid_write};
      S_IFFL:   return {6'b0, if_flush};
      S_EXV:    return {6'b0, ex_valid};
      S_EXSRC:  return {6'b0, ex_alu_src};
      S_EXJAL:  return {6'b0, ex_is_jal};
      S_EXJALR: return {6'b0, ex_is_jalr};
      S_EXBR:   return {6'b0, ex_branch};
      S_EXOP:   return ex_alu_op;
      S_MEMV:   return {6'b0, mem_valid};
      S_MEMRD:  return {6'b0, mem_read};
      S_MEMWR:  return {6'b0, mem_write};
      S_WBV:    return {6'b0, wb_valid};
      S_WBM2R:  return {6'b0, wb_mem_to_reg};
      S_WBRW:   return {6'b0, wb_reg_write};
      S_WBPC:   return {6'b0, wb_pc_to_reg};
      S_HALT:   return {6'b0, halted};
      S_ILL:    return {6'b0, illegal_inst};
      S_D2HALT: return {6'b0, d2_halted};
      S_D2PCW:  return {6'b0, d2_pc_write};
      default:  return 7'h7f;
    endcase
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_at(input int dc, input int s, input logic [6:0] v, input string tag);
    exp_t e;
    e.cyc = cur + dc;
    e.sig = s;
    e.val = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Drive one cycle of ID inputs, then compare every expectation due this cycle.
  task automatic step(input logic [6:0] op, input logic v, input logic c,
                      input logic st, input logic fl);
    int i;
    opcode = op; id_valid = v; ecall_halt_cond = c; stall = st; flush = fl;
    @(negedge clk);
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cur) begin
        check(sb[i].tag, get_sig(sb[i].sig), sb[i].val);
        sb.delete(i);
      end else begin
        i++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flag_expired();
    while (sb.size() > 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s_expired: observed none expected %0h", sb[0].tag, sb[0].val);
      sb.delete(0);
    end
  endtask

  task automatic do_reset();
    flag_expired();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked while reset is held low.
    #3;
    check("rst_halted", {6'b0, halted}, 7'd0);
    check("rst_illegal", {6'b0, illegal_inst}, 7'd0);
    check("rst_pc_write", {6'b0, pc_write}, 7'd1);
    check("rst_ifid_write", {6'b0, ifid_write}, 7'd1);
    check("rst_if_flush", {6'b0, if_flush}, 7'd0);
    check("rst_ex_valid", {6'b0, ex_valid}, 7'd0);
    check("rst_mem_valid", {6'b0, mem_valid}, 7'd0);
    check("rst_wb_valid", {6'b0, wb_valid}, 7'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // LOAD, ADD, SW back to back.
    expect_at(1, S_EXSRC, 7'd1, "ld_ex_alu_src");
    expect_at(1, S_EXOP, OP_LD, "ld_ex_alu_op");
    expect_at(2, S_MEMRD, 7'd1, "ld_mem_read");
    expect_at(3, S_WBM2R, 7'd1, "ld_wb_mem_to_reg");
    expect_at(3, S_WBRW, 7'd1, "ld_wb_reg_write");
    step(OP_LD, 1, 0, 0, 0);
    expect_at(1, S_EXOP, OP_R, "add_ex_alu_op");
    expect_at(1, S_EXSRC, 7'd0, "add_ex_alu_src");
    expect_at(2, S_MEMRD, 7'd0, "add_mem_read");
    step(OP_R, 1, 0, 0, 0);
    expect_at(1, S_EXSRC, 7'd1, "sw_ex_alu_src");
    expect_at(2, S_MEMWR, 7'd1, "sw_mem_write");
    expect_at(3, S_WBV, 7'd1, "sw_wb_valid");
    expect_at(3, S_WBRW, 7'd0, "sw_wb_reg_write");
    step(OP_SW, 1, 0, 0, 0);
    // BRANCH, JAL, JALR, I-type.
    expect_at(1, S_EXBR, 7'd1, "br_ex_branch");
    expect_at(1, S_EXSRC, 7'd0, "br_ex_alu_src");
    step(OP_BR, 1, 0, 0, 0);
    expect_at(1, S_EXJAL, 7'd1, "jal_ex_is_jal");
    expect_at(1, S_EXSRC, 7'd1, "jal_ex_alu_src");
    expect_at(3, S_WBPC, 7'd1, "jal_wb_pc_to_reg");
    expect_at(3, S_WBRW, 7'd1, "jal_wb_reg_write");
    step(OP_JAL, 1, 0, 0, 0);
    expect_at(1, S_EXJALR, 7'd1, "jalr_ex_is_jalr");
    expect_at(1, S_EXJAL, 7'd0, "jalr_ex_is_jal");
    expect_at(3, S_WBPC, 7'd1, "jalr_wb_pc_to_reg");
    step(OP_JALR, 1, 0, 0, 0);
    expect_at(1, S_EXSRC, 7'd1, "itype_ex_alu_src");
    expect_at(3, S_WBRW, 7'd1, "itype_wb_reg_write");
    expect_at(3, S_WBPC, 7'd0, "itype_wb_pc_to_reg");
    step(OP_I, 1, 0, 0, 0);
    idle(4);

    // Load-use stall: ADD held in ID for one cycle.
    step(OP_LD, 1, 0, 0, 0);
    expect_at(0, S_PCW, 7'd0, "stall_pc_write");
    expect_at(0, S_IFIDW, 7'd0, "stall_ifid_write");
    expect_at(0, S_EXOP, OP_LD, "stall_ld_in_ex");
    expect_at(1, S_EXV, 7'd0, "stall_bubble_ex_valid");
    expect_at(1, S_MEMRD, 7'd1, "stall_ld_mem_read");
    step(OP_R, 1, 0, 1, 0);
    expect_at(1, S_EXV, 7'd1, "stall_add_ex_valid");
    expect_at(1, S_EXOP, OP_R, "stall_add_ex_alu_op");
    step(OP_R, 1, 0, 0, 0);
    idle(3);

    // Flush and stall together squash a halting ECALL.
    expect_at(0, S_IFFL, 7'd1, "flush_if_flush");
    expect_at(0, S_PCW, 7'd1, "flush_pc_write");
    expect_at(0, S_IFIDW, 7'd1, "flush_ifid_write");
    expect_at(1, S_EXV, 7'd0, "flush_ex_valid");
    expect_at(1, S_PCW, 7'd1, "flush_still_run");
    expect_at(4, S_HALT, 7'd0, "flush_no_halt");
    step(OP_EC, 1, 1, 1, 1);
    idle(5);

    // Non-halting ECALL passes through.
    expect_at(1, S_EXV, 7'd1, "ec0_ex_valid");
    expect_at(1, S_EXOP, OP_EC, "ec0_ex_alu_op");
    expect_at(1, S_EXSRC, 7'd0, "ec0_ex_alu_src");
    expect_at(1, S_PCW, 7'd1, "ec0_pc_write");
    expect_at(3, S_WBV, 7'd1, "ec0_wb_valid");
    expect_at(3, S_WBRW, 7'd0, "ec0_wb_reg_write");
    expect_at(4, S_HALT, 7'd0, "ec0_no_halt");
    step(OP_EC, 1, 0, 0, 0);
    idle(5);

    // Halting ECALL; a flush during DRAIN is ignored.
    expect_at(0, S_PCW, 7'd1, "ec1_pc_write_t");
    expect_at(1, S_PCW, 7'd0, "ec1_pc_write_t1");
    expect_at(1, S_IFIDW, 7'd0, "ec1_ifid_write_t1");
    expect_at(1, S_IFFL, 7'd0, "ec1_flush_ignored");
    expect_at(1, S_EXV, 7'd1, "ec1_ex_valid");
    expect_at(2, S_EXV, 7'd0, "ec1_drain_bubble");
    expect_at(2, S_MEMV, 7'd1, "ec1_mem_valid");
    expect_at(3, S_WBV, 7'd1, "ec1_wb_valid");
    expect_at(3, S_HALT, 7'd0, "ec1_halt_t3");
    expect_at(4, S_HALT, 7'd1, "ec1_halt_t4");
    expect_at(5, S_HALT, 7'd1, "ec1_halt_t5");
    expect_at(5, S_PCW, 7'd0, "ec1_halted_pc_write");
    expect_at(5, S_ILL, 7'd0, "ec1_no_illegal");
    step(OP_EC, 1, 1, 0, 0);
    step(OP_R, 1, 0, 0, 1);
    idle(4);
    do_reset();

    // Illegal opcode: sticky flag, no halt on dut, halt after 2-cycle drain on dut2.
    expect_at(0, S_ILL, 7'd0, "ill_flag_t");
    expect_at(1, S_ILL, 7'd1, "ill_flag_t1");
    expect_at(1, S_EXSRC, 7'd0, "ill_ex_alu_src");
    expect_at(1, S_EXOP, 7'd0, "ill_ex_alu_op");
    expect_at(1, S_EXJAL, 7'd0, "ill_ex_is_jal");
    expect_at(2, S_MEMRD, 7'd0, "ill_mem_read");
    expect_at(2, S_MEMWR, 7'd0, "ill_mem_write");
    expect_at(3, S_WBRW, 7'd0, "ill_wb_reg_write");
    expect_at(4, S_HALT, 7'd0, "ill_no_halt");
    expect_at(4, S_PCW, 7'd1, "ill_pc_write");
    expect_at(5, S_ILL, 7'd1, "ill_flag_sticky");
    expect_at(1, S_D2PCW, 7'd0, "ill2_pc_write_t1");
    expect_at(2, S_D2HALT, 7'd0, "ill2_halt_t2");
    expect_at(3, S_D2HALT, 7'd1, "ill2_halt_t3");
    step(OP_BAD, 1, 0, 0, 0);
    idle(5);
    do_reset();

    // Asynchronous reset pulse in the middle of DRAIN.
    expect_at(1, S_PCW, 7'd0, "mid_drain_pc_write");
    step(OP_EC, 1, 1, 0, 0);
    idle(1);
    reset = 1'b0;
    #2;
    check("async_rst_pc_write", {6'b0, pc_write}, 7'd1);
    check("async_rst_ifid_write", {6'b0, ifid_write}, 7'd1);
    check("async_rst_halted", {6'b0, halted}, 7'd0);
    check("async_rst_mem_valid", {6'b0, mem_valid}, 7'd0);
    #1;
    reset = 1'b1;
    expect_at(0, S_PCW, 7'd1, "post_rst_pc_write");
    expect_at(1, S_EXV, 7'd1, "post_rst_ex_valid");
    expect_at(1, S_EXOP, OP_R, "post_rst_ex_alu_op");
    expect_at(1, S_EXSRC, 7'd0, "post_rst_ex_alu_src");
    expect_at(3, S_WBRW, 7'd1, "post_rst_wb_reg_write");
    expect_at(4, S_HALT, 7'd0, "post_rst_no_halt");
    step(OP_R, 1, 0, 0, 0);
    idle(5);
    flag_expired();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
